// File: rtl/rvvi_trace_pkg.sv
// rvvi_trace_pkg: shared constants and writeback-mask helper for the RVVI trace bridge
package rvvi_trace_pkg;
  localparam int ORDER_W = 64;
  localparam int X_REGS = 32;
  function automatic logic [X_REGS-1:0] onehot(input logic en, input logic [4:0] idx);
    return en ? X_REGS'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: generic synchronous FIFO with registered fill level
module trace_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // payload storage needs no reset: it is only read when level is non-zero
  always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign rdata = mem[rd_ptr];
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/rvvi_trace_bridge.sv
// rvvi_trace_bridge: buffers RVFI retire records and presents them as RVVI records
module rvvi_trace_bridge
  import rvvi_trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int FLEN = 32,
  parameter bit ISA_F = 1'b0,
  parameter int DEPTH = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  input  logic [ORDER_W-1:0]     in_order_i,
  input  logic [31:0]            in_insn_i,
  input  logic [XLEN-1:0]        in_pc_rdata_i,
  input  logic [XLEN-1:0]        in_pc_wdata_i,
  input  logic                   in_trap_i,
  input  logic                   in_intr_i,
  input  logic                   in_halt_i,
  input  logic [1:0]             in_mode_i,
  input  logic [4:0]             in_rd_addr_i,
  input  logic [XLEN-1:0]        in_rd_wdata_i,
  input  logic                   in_frd_we_i,
  input  logic [4:0]             in_frd_addr_i,
  input  logic [FLEN-1:0]        in_frd_wdata_i,
  input  logic                   in_csr_we_i,
  input  logic [11:0]            in_csr_addr_i,
  input  logic [XLEN-1:0]        in_csr_wdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [ORDER_W-1:0]     out_order_o,
  output logic [31:0]            out_insn_o,
  output logic [XLEN-1:0]        out_pc_rdata_o,
  output logic [XLEN-1:0]        out_pc_wdata_o,
  output logic                   out_trap_o,
  output logic                   out_intr_o,
  output logic                   out_halt_o,
  output logic [1:0]             out_mode_o,
  output logic [X_REGS-1:0]      out_x_wb_o,
  output logic [XLEN-1:0]        out_x_wdata_o,
  output logic [X_REGS-1:0]      out_f_wb_o,
  output logic [FLEN-1:0]        out_f_wdata_o,
  output logic                   out_csr_wb_o,
  output logic [11:0]            out_csr_addr_o,
  output logic [XLEN-1:0]        out_csr_wdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   stall_o,
  output logic                   overflow_o,
  output logic                   order_err_o
);
  localparam int LW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic               trap;
    logic               intr;
    logic               halt;
    logic [1:0]         mode;
    logic [X_REGS-1:0]  x_wb;
    logic [XLEN-1:0]    x_wdata;
    logic [X_REGS-1:0]  f_wb;
    logic [FLEN-1:0]    f_wdata;
    logic               csr_wb;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
  } trace_rec_t;
  trace_rec_t enc, head, shown;
  logic push, pop, full, empty, f_we, x_we;
  logic [LW-1:0] next_level;
  logic [ORDER_W-1:0] exp_order;
  // encode the retire into its stored form; unwritten destinations carry zero data
  always_comb begin
    x_we = in_rd_addr_i != 5'd0;
    f_we = ISA_F && in_frd_we_i;
    enc = '{
      order: in_order_i, insn: in_insn_i, pc_rdata: in_pc_rdata_i, pc_wdata: in_pc_wdata_i,
      trap: in_trap_i, intr: in_intr_i, halt: in_halt_i, mode: in_mode_i,
      x_wb: onehot(x_we, in_rd_addr_i), x_wdata: x_we ? in_rd_wdata_i : '0,
      f_wb: onehot(f_we, in_frd_addr_i), f_wdata: f_we ? in_frd_wdata_i : '0,
      csr_wb: in_csr_we_i, csr_addr: in_csr_we_i ? in_csr_addr_i : '0,
      csr_wdata: in_csr_we_i ? in_csr_wdata_i : '0};
    pop = !empty && out_ready_i;
    push = in_valid_i && (!full || pop);
    next_level = level_o + LW'(push) - LW'(pop);
    shown = empty ? '0 : head;
  end
  trace_fifo #(.T(trace_rec_t), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(push), .pop(pop), .wdata(enc), .rdata(head),
    .full(full), .empty(empty), .level(level_o));
  // almost-full stall, sticky drop/order flags and expected-order tracking
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stall_o     <= 1'b0;
      overflow_o  <= 1'b0;
      order_err_o <= 1'b0;
      exp_order   <= '0;
    end else begin
      stall_o <= next_level >= LW'(DEPTH - STALL_MARGIN);
      if (in_valid_i && !push) overflow_o <= 1'b1;
      if (in_valid_i && in_order_i != exp_order) order_err_o <= 1'b1;
      if (in_valid_i) exp_order <= in_order_i + 1'b1;
    end
  assign out_valid_o     = !empty;
  assign out_order_o     = shown.order;
  assign out_insn_o      = shown.insn;
  assign out_pc_rdata_o  = shown.pc_rdata;
  assign out_pc_wdata_o  = shown.pc_wdata;
  assign out_trap_o      = shown.trap;
  assign out_intr_o      = shown.intr;
  assign out_halt_o      = shown.halt;
  assign out_mode_o      = shown.mode;
  assign out_x_wb_o      = shown.x_wb;
  assign out_x_wdata_o   = shown.x_wdata;
  assign out_f_wb_o      = shown.f_wb;
  assign out_f_wdata_o   = shown.f_wdata;
  assign out_csr_wb_o    = shown.csr_wb;
  assign out_csr_addr_o  = shown.csr_addr;
  assign out_csr_wdata_o = shown.csr_wdata;
endmodule
